// File: rtl/gshare_update_scheduler.sv
// Update scheduler for a gshare predictor: keeps an in-order queue of in-flight branches,
// issues one registered predictor write per resolve and flushes younger work on a mispredict.
module gshare_update_scheduler #(
    parameter int unsigned HISTORY_LEN = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     alloc_valid_i,
    input  logic [HISTORY_LEN-1:0]   alloc_pc_bits_i,
    input  logic [HISTORY_LEN-1:0]   alloc_history_i,
    input  logic                     alloc_prediction_i,
    output logic                     alloc_ready_o,
    input  logic                     resolve_valid_i,
    input  logic                     resolve_taken_i,
    output logic                     update_en_o,
    output logic [HISTORY_LEN-1:0]   pc_bits_write_o,
    output logic [HISTORY_LEN-1:0]   history_write_o,
    output logic                     outcome_o,
    output logic                     flush_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         branch_count_o,
    output logic [CNT_W-1:0]         mispredict_count_o,
    output logic                     error_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthV = DEPTH[PtrW:0];

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [HISTORY_LEN-1:0] pc_mem_q   [DEPTH];
    logic [HISTORY_LEN-1:0] hist_mem_q [DEPTH];
    logic [DEPTH-1:0]       pred_mem_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PtrW:0]          wcnt_q, wcnt_d;
    logic [PtrW:0]          rcnt_q, rcnt_d;
    logic [PtrW-1:0]        wptr, rptr;
    logic [PtrW:0]          occ, occ_d;

    logic                   alloc_ready_q, alloc_ready_d;
    logic                   update_en_q, update_en_d;
    logic                   flush_q, flush_d;
    logic [HISTORY_LEN-1:0] pc_write_q, pc_write_d;
    logic [HISTORY_LEN-1:0] hist_write_q, hist_write_d;
    logic                   outcome_q, outcome_d;
    logic [CNT_W-1:0]       branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]       mispred_cnt_q, mispred_cnt_d;
    logic                   error_q, error_d;

    logic                   push;
    logic                   resolve_ok;
    logic                   mispredict;

    assign wptr = wcnt_q[PtrW-1:0];
    assign rptr = rcnt_q[PtrW-1:0];
    assign occ  = wcnt_q - rcnt_q;

    always_comb begin
        push          = alloc_valid_i && alloc_ready_q;
        resolve_ok    = (state_q == StIdle) && resolve_valid_i && (occ != '0);
        mispredict    = resolve_ok && (resolve_taken_i != pred_mem_q[rptr]);

        state_d       = StIdle;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        update_en_d   = resolve_ok;
        flush_d       = mispredict;
        pc_write_d    = pc_write_q;
        hist_write_d  = hist_write_q;
        outcome_d     = outcome_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        error_d       = error_q;

        if (resolve_ok) begin
            pc_write_d   = pc_mem_q[rptr];
            hist_write_d = hist_mem_q[rptr];
            outcome_d    = resolve_taken_i;
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
        end

        if ((state_q == StIdle) && resolve_valid_i && (occ == '0)) begin
            error_d = 1'b1;
        end

        if (mispredict) begin
            // Everything still queued, plus any alloc accepted this cycle, is younger.
            wcnt_d  = '0;
            rcnt_d  = '0;
            state_d = StFlush;
            if (mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end else begin
            if (push) begin
                wcnt_d = wcnt_q + 1'b1;
            end
            if (resolve_ok) begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        occ_d         = wcnt_d - rcnt_d;
        alloc_ready_d = (occ_d < DepthV) && (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            alloc_ready_q <= 1'b0;
            update_en_q   <= 1'b0;
            flush_q       <= 1'b0;
            pc_write_q    <= '0;
            hist_write_q  <= '0;
            outcome_q     <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            alloc_ready_q <= alloc_ready_d;
            update_en_q   <= update_en_d;
            flush_q       <= flush_d;
            pc_write_q    <= pc_write_d;
            hist_write_q  <= hist_write_d;
            outcome_q     <= outcome_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            error_q       <= error_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                hist_mem_q[i] <= '0;
            end
            pred_mem_q <= '0;
        end else if (push && !mispredict) begin
            pc_mem_q[wptr]   <= alloc_pc_bits_i;
            hist_mem_q[wptr] <= alloc_history_i;
            pred_mem_q[wptr] <= alloc_prediction_i;
        end
    end

    assign alloc_ready_o      = alloc_ready_q;
    assign update_en_o        = update_en_q;
    assign flush_o            = flush_q;
    assign pc_bits_write_o    = pc_write_q;
    assign history_write_o    = hist_write_q;
    assign outcome_o          = outcome_q;
    assign occupancy_o        = occ;
    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispred_cnt_q;
    assign error_o            = error_q;

endmodule

// File: tb/tb_gshare_update_scheduler.sv
// Bench for gshare_update_scheduler: a queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_gshare_update_scheduler;

    localparam int unsigned HL  = 8;
    localparam int unsigned DEP = 4;
    localparam int unsigned CW  = 16;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          alloc_valid = 1'b0;
    logic [HL-1:0] alloc_pc_bits = '0;
    logic [HL-1:0] alloc_history = '0;
    logic          alloc_prediction = 1'b0;
    logic          resolve_valid = 1'b0;
    logic          resolve_taken = 1'b0;

    logic          alloc_ready;
    logic          update_en;
    logic [HL-1:0] pc_bits_write;
    logic [HL-1:0] history_write;
    logic          outcome;
    logic          flush;
    logic [2:0]    occupancy;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;
    logic          error;

    int vectors = 0;
    int miscompares = 0;

    gshare_update_scheduler #(
        .HISTORY_LEN (HL),
        .DEPTH       (DEP),
        .CNT_W       (CW)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .alloc_valid_i      (alloc_valid),
        .alloc_pc_bits_i    (alloc_pc_bits),
        .alloc_history_i    (alloc_history),
        .alloc_prediction_i (alloc_prediction),
        .alloc_ready_o      (alloc_ready),
        .resolve_valid_i    (resolve_valid),
        .resolve_taken_i    (resolve_taken),
        .update_en_o        (update_en),
        .pc_bits_write_o    (pc_bits_write),
        .history_write_o    (history_write),
        .outcome_o          (outcome),
        .flush_o            (flush),
        .occupancy_o        (occupancy),
        .branch_count_o     (branch_count),
        .mispredict_count_o (mispredict_count),
        .error_o            (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [HL-1:0] pc;
        logic [HL-1:0] hist;
        logic          pred;
    } ent_t;

    ent_t          m_q[$];
    logic          m_inflush = 1'b0;
    logic          m_ready = 1'b0;
    logic          m_upd = 1'b0;
    logic          m_flush = 1'b0;
    logic [HL-1:0] m_pcw = '0;
    logic [HL-1:0] m_hw = '0;
    logic          m_out = 1'b0;
    logic [CW-1:0] m_bc = '0;
    logic [CW-1:0] m_mc = '0;
    logic          m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflush = 1'b0;
        m_ready   = 1'b0;
        m_upd     = 1'b0;
        m_flush   = 1'b0;
        m_pcw     = '0;
        m_hw      = '0;
        m_out     = 1'b0;
        m_bc      = '0;
        m_mc      = '0;
        m_err     = 1'b0;
    endtask

    // One clock of the queue-level behaviour, using the inputs present at the edge.
    task automatic model_step();
        ent_t head;
        ent_t nw;
        logic accept;
        nw      = '{pc: alloc_pc_bits, hist: alloc_history, pred: alloc_prediction};
        accept  = alloc_valid && m_ready;
        m_upd   = 1'b0;
        m_flush = 1'b0;
        if (m_inflush) begin
            m_inflush = 1'b0;
        end else begin
            if (resolve_valid) begin
                if (m_q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    head  = m_q.pop_front();
                    m_upd = 1'b1;
                    m_pcw = head.pc;
                    m_hw  = head.hist;
                    m_out = resolve_taken;
                    if (m_bc != 16'hFFFF) m_bc = m_bc + 1;
                    if (resolve_taken != head.pred) begin
                        m_flush = 1'b1;
                        if (m_mc != 16'hFFFF) m_mc = m_mc + 1;
                        m_q.delete();
                        accept    = 1'b0;
                        m_inflush = 1'b1;
                    end
                end
            end
            if (accept) m_q.push_back(nw);
        end
        m_ready = (m_q.size() < DEP) && !m_inflush;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("alloc_ready", 32'(alloc_ready), 32'(m_ready));
            chk("update_en", 32'(update_en), 32'(m_upd));
            chk("flush", 32'(flush), 32'(m_flush));
            chk("pc_bits_write", 32'(pc_bits_write), 32'(m_pcw));
            chk("history_write", 32'(history_write), 32'(m_hw));
            chk("outcome", 32'(outcome), 32'(m_out));
            chk("occupancy", 32'(occupancy), 32'(m_q.size()));
            chk("branch_count", 32'(branch_count), 32'(m_bc));
            chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
            chk("error", 32'(error), 32'(m_err));
        end
    end

    // Apply inputs for one cycle; returns 2 time units after the edge that consumed them.
    task automatic cyc(input logic av, input logic [HL-1:0] pc, input logic [HL-1:0] h,
                       input logic pr, input logic rv, input logic rt);
        alloc_valid      = av;
        alloc_pc_bits    = pc;
        alloc_history    = h;
        alloc_prediction = pr;
        resolve_valid    = rv;
        resolve_taken    = rt;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #2;
        chk("rst alloc_ready", 32'(alloc_ready), 32'd0);
        chk("rst occupancy", 32'(occupancy), 32'd0);
        chk("rst update_en", 32'(update_en), 32'd0);
        rst_ni = 1'b1;
        idle();
        chk("ready after reset", 32'(alloc_ready), 32'd1);

        // In-order training, all predictions correct.
        cyc(1'b1, 8'h11, 8'hA0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 8'hA1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 8'hA2, 1'b0, 1'b0, 1'b0);
        chk("occ 3", 32'(occupancy), 32'd3);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("upd1 en", 32'(update_en), 32'd1);
        chk("upd1 pc", 32'(pc_bits_write), 32'h11);
        chk("upd1 hist", 32'(history_write), 32'hA0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("upd2 pc", 32'(pc_bits_write), 32'h22);
        chk("upd2 hist", 32'(history_write), 32'hA1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("upd3 en", 32'(update_en), 32'd1);
        chk("upd3 pc", 32'(pc_bits_write), 32'h33);
        chk("upd3 outcome", 32'(outcome), 32'd0);
        chk("upd3 flush", 32'(flush), 32'd0);
        idle();
        chk("upd hold pc", 32'(pc_bits_write), 32'h33);
        chk("bc 3", 32'(branch_count), 32'd3);
        chk("occ drained", 32'(occupancy), 32'd0);

        // Full queue: alloc refused when coincident with a resolve.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 8'(8'hB0 + i), 1'b1, 1'b0, 1'b0);
        chk("full ready", 32'(alloc_ready), 32'd0);
        chk("full occ", 32'(occupancy), 32'd4);
        cyc(1'b1, 8'h50, 8'hC0, 1'b1, 1'b1, 1'b1);
        chk("refused occ", 32'(occupancy), 32'd3);
        chk("refused pc", 32'(pc_bits_write), 32'h40);
        cyc(1'b1, 8'h51, 8'hC1, 1'b1, 1'b0, 1'b0);
        chk("accepted occ", 32'(occupancy), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("last drained pc", 32'(pc_bits_write), 32'h51);
        idle();

        // Mispredict with a coincident alloc.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h60 + i), 8'(8'hD0 + i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h70, 8'hE0, 1'b1, 1'b1, 1'b0);
        chk("mp flush", 32'(flush), 32'd1);
        chk("mp update_en", 32'(update_en), 32'd1);
        chk("mp outcome", 32'(outcome), 32'd0);
        chk("mp pc", 32'(pc_bits_write), 32'h60);
        chk("mp ready", 32'(alloc_ready), 32'd0);
        chk("mp occ", 32'(occupancy), 32'd0);
        chk("mp count", 32'(mispredict_count), 32'd1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("post flush ready", 32'(alloc_ready), 32'd1);
        chk("post flush no upd", 32'(update_en), 32'd0);
        chk("flush ignores resolve", 32'(error), 32'd0);
        chk("bc 9", 32'(branch_count), 32'd9);

        // Resolve with empty queue sets the sticky error.
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("empty upd", 32'(update_en), 32'd0);
        chk("empty error", 32'(error), 32'd1);
        chk("empty bc", 32'(branch_count), 32'd9);
        cyc(1'b1, 8'h80, 8'hF0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("error sticky", 32'(error), 32'd1);
        chk("bc 10", 32'(branch_count), 32'd10);

        // Stream correct resolves up to the saturation edge.
        cyc(1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_bc < 16'hFFFE && guard < 70000) begin
            cyc(1'b1, 8'(guard), 8'(guard + 1), 1'b1, 1'b1, 1'b1);
            guard++;
        end
        idle();
        chk("near sat", 32'(branch_count), 32'hFFFE);
        cyc(1'b1, 8'h90, 8'h91, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("sat 1", 32'(branch_count), 32'hFFFF);
        chk("sat pc", 32'(pc_bits_write), 32'h90);
        idle();

        // Asynchronous reset while a mispredict's flush is visible.
        cyc(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("pre-rst flush", 32'(flush), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst upd", 32'(update_en), 32'd0);
        chk("rst occ", 32'(occupancy), 32'd0);
        chk("rst bc", 32'(branch_count), 32'd0);
        chk("rst mc", 32'(mispredict_count), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        idle();
        idle();
        chk("final ready", 32'(alloc_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gshare_update_scheduler.md
Name: gshare_update_scheduler

Overview:
- Sequences training of the gshare branch predictor: tracks in-flight predicted branches from fetch in an in-order queue.
- Issues one predictor update per resolved branch (update_en, pc_bits_write, history_write, outcome).
- Detects mispredictions and raises a one-cycle flush to the pipeline, squashing all younger in-flight entries.
- Sits between fetch (allocate), execute (resolve) and the predictor's write port.

Parameters:
- HISTORY_LEN, 8, width of PC index bits and global history snapshot.
- DEPTH, 4, in-flight branch queue entries (power of two, >=2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- alloc_valid  input  1  fetch has a predicted branch this cycle.
- alloc_pc_bits  input  HISTORY_LEN  PC index bits of fetched branch.
- alloc_history  input  HISTORY_LEN  global history used for its prediction.
- alloc_prediction  input  1  predicted direction (1 = taken).
- alloc_ready  output  1  allocation accepted this cycle; fetch stalls when low.
- resolve_valid  input  1  oldest in-flight branch resolved this cycle.
- resolve_taken  input  1  actual direction.
- update_en  output  1  predictor write strobe.
- pc_bits_write  output  HISTORY_LEN  predictor write PC bits.
- history_write  output  HISTORY_LEN  predictor write history.
- outcome  output  1  predictor training direction.
- flush  output  1  mispredict pulse to pipeline.
- occupancy  output  $clog2(DEPTH)+1  valid queue entries.
- branch_count  output  CNT_W  resolved branches, saturating.
- mispredict_count  output  CNT_W  mispredicted branches, saturating.
- error  output  1  sticky: resolve arrived with empty queue.

Behaviour:
- Reset (reset low, asynchronous): queue empty, read and write pointers 0, state IDLE, all outputs 0 except alloc_ready, which becomes 1 on the first clock edge after reset deasserts.
- Queue: circular FIFO of {pc_bits, history, prediction}.
  - Entry written on alloc_valid && alloc_ready.
  - Pointers wrap modulo DEPTH.
  - occupancy = write count minus read count.
- alloc_ready = (occupancy < DEPTH) && state == IDLE.
- Full queue with alloc and resolve in the same cycle: the alloc is refused (no bypass). The resolve proceeds.
- States:
  - IDLE: normal operation.
  - FLUSH: one cycle, entered after a mispredict. alloc_ready = 0; resolve_valid is ignored (error not set). Returns to IDLE unconditionally.
- Resolve in IDLE with occupancy > 0, cycle N:
  - Head entry popped at the edge ending cycle N.
  - update_en = 1 during cycle N+1, registered.
  - pc_bits_write and history_write are from the head entry; outcome = resolve_taken.
  - Outputs hold their last values when update_en = 0.
  - branch_count increments (saturating at all-ones).
- Mispredict (resolve_taken != head prediction):
  - flush = 1 during cycle N+1, coincident with update_en.
  - mispredict_count increments (saturating).
  - Queue cleared at the edge ending cycle N; any alloc accepted in cycle N is also discarded, because it is younger.
  - State goes to FLUSH for cycle N+1, so alloc_ready = 0 in N+1.
- Correct prediction: no flush; state stays IDLE.
- Simultaneous alloc and resolve in IDLE, no mispredict, not full: both take effect; occupancy unchanged.
- Resolve with occupancy == 0 in IDLE: no update and no counter change; error set (sticky until reset).
- Exactly one update per resolved branch, at most one per cycle. Back-to-back resolves give back-to-back update_en cycles.
- Reset asserted mid-flush or mid-update: all state cleared immediately; the pending update_en/flush is dropped.

Test Plan:
- Reset, then alloc 3 branches (pc 0x11/0x22/0x33, hist 0xA0/0xA1/0xA2, pred 1/1/0); resolve taken 1, 1, 0 on consecutive cycles -> update_en on 3 consecutive cycles with pc_bits_write 0x11, 0x22, 0x33 and history_write 0xA0, 0xA1, 0xA2; flush never asserted; branch_count = 3; occupancy returns to 0.
- Alloc 4 entries with DEPTH = 4 -> alloc_ready = 0, occupancy = 4. Then alloc plus correct resolve in the same cycle -> alloc refused, occupancy = 3; the next cycle's alloc is accepted.
- Alloc 3 entries, resolve head with taken != prediction while alloc_valid is high -> next cycle flush = 1, update_en = 1, outcome = actual direction; alloc_ready = 0 for that cycle; occupancy = 0; mispredict_count = 1; the cycle after, alloc_ready = 1.
- Resolve with empty queue -> update_en stays 0, error = 1 and stays 1 through later normal traffic until reset.
- Preload counters near saturation (0xFFFE) via 2 resolves -> branch_count stops at 0xFFFF.
- Assert reset low asynchronously in the cycle a mispredict is registered -> flush and update_en are 0 immediately; occupancy = 0; counters = 0.
